// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle controller: FSM states, instruction
// classes, RV opcodes and ALU operation codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_ADDI = 3'd2,
    CLS_LD   = 3'd3,
    CLS_SD   = 3'd4,
    CLS_BEQ  = 3'd5
  } iclass_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  function automatic iclass_t classify(input logic [6:0] opcode);
    iclass_t cls;
    case (opcode)
      OP_R:    cls = CLS_R;
      OP_ADDI: cls = CLS_ADDI;
      OP_LD:   cls = CLS_LD;
      OP_SD:   cls = CLS_SD;
      OP_BEQ:  cls = CLS_BEQ;
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath.
interface multicycle_controller_if;
  logic [31:0] instruction;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_write;
  logic        dmem_req;
  logic        mem_read;
  logic        mem_write;
  logic        mdr_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic        branch;
  logic        pc_write;
  logic        pc_src;
  logic        halted;
  logic        illegal;
  logic [63:0] instret;
  logic [2:0]  state;

  modport master (
    input  instruction, zero, imem_ready, dmem_ready,
    output imem_req, ir_write, dmem_req, mem_read, mem_write, mdr_write,
           reg_write, mem_to_reg, alu_src, alu_ctrl, branch, pc_write,
           pc_src, halted, illegal, instret, state
  );

  modport slave (
    output instruction, zero, imem_ready, dmem_ready,
    input  imem_req, ir_write, dmem_req, mem_read, mem_write, mdr_write,
           reg_write, mem_to_reg, alu_src, alu_ctrl, branch, pc_write,
           pc_src, halted, illegal, instret, state
  );
endinterface

// File: rtl/alu_control.sv
// Combinational ALU operation select from instruction class and funct fields.
module alu_control
  import ctrl_pkg::*;
(
  input  iclass_t    cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl,
  output logic       r_illegal
);

  always_comb begin
    alu_ctrl  = ALU_AND;
    r_illegal = 1'b0;
    case (cls)
      CLS_R: begin
        case (funct3)
          3'b000:  alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          default: r_illegal = 1'b1;
        endcase
      end
      CLS_ADDI, CLS_LD, CLS_SD: alu_ctrl = ALU_ADD;
      CLS_BEQ:                  alu_ctrl = ALU_SUB;
      default:                  alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM with req/ready memory handshakes, sticky halt and
// a retired-instruction counter.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_t      state_q, state_d;
  logic        illegal_q;
  logic        set_illegal;
  logic        retire;
  logic [63:0] instret_q;
  iclass_t     cls, alu_cls;
  logic [3:0]  alu_code;
  logic        r_illegal;
  logic        is_ld;

  assign cls     = classify(bus.instruction[6:0]);
  assign is_ld   = (cls == CLS_LD);
  // ALU select only decodes in EXECUTE so alu_ctrl reads 0 elsewhere
  assign alu_cls = (state_q == ST_EXECUTE) ? cls : CLS_NONE;

  alu_control u_alu_control (
    .cls       (alu_cls),
    .funct3    (bus.instruction[14:12]),
    .funct7_5  (bus.instruction[30]),
    .alu_ctrl  (alu_code),
    .r_illegal (r_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (retire)      instret_q <= instret_q + 64'd1;
    end
  end

  always_comb begin
    state_d        = state_q;
    set_illegal    = 1'b0;
    retire         = 1'b0;
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mdr_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src    = 1'b0;
    bus.branch     = 1'b0;
    bus.pc_src     = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_write = 1'b1;
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (bus.instruction == 32'd0) begin
          state_d = ST_HALT;
        end else if (cls == CLS_NONE) begin
          state_d     = ST_HALT;
          set_illegal = 1'b1;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        case (cls)
          CLS_R: begin
            if (r_illegal) begin
              state_d     = ST_HALT;
              set_illegal = 1'b1;
            end else begin
              state_d = ST_WRITEBACK;
            end
          end
          CLS_ADDI: begin
            bus.alu_src = 1'b1;
            state_d     = ST_WRITEBACK;
          end
          CLS_LD, CLS_SD: begin
            bus.alu_src = 1'b1;
            state_d     = ST_MEMORY;
          end
          CLS_BEQ: begin
            bus.branch = 1'b1;
            bus.pc_src = bus.zero;
            retire     = 1'b1;
            state_d    = ST_FETCH;
          end
          default: state_d = ST_HALT;
        endcase
      end
      ST_MEMORY: begin
        bus.dmem_req  = 1'b1;
        bus.mem_read  = is_ld;
        bus.mem_write = !is_ld;
        if (bus.dmem_ready) begin
          if (is_ld) begin
            bus.mdr_write = 1'b1;
            state_d       = ST_WRITEBACK;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_WRITEBACK: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = is_ld;
        retire         = 1'b1;
        state_d        = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pc_write = retire;
  assign bus.alu_ctrl = alu_code;
  assign bus.halted   = (state_q == ST_HALT);
  assign bus.illegal  = illegal_q;
  assign bus.instret  = instret_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-table bench for multicycle_controller plus a hand sequence for an
// asynchronous reset landing in the MEMORY state of a store.
module tb_multicycle_controller;

  localparam logic [13:0] IMREQ = 14'h2000;
  localparam logic [13:0] IRW   = 14'h1000;
  localparam logic [13:0] DREQ  = 14'h0800;
  localparam logic [13:0] MRD   = 14'h0400;
  localparam logic [13:0] MWR   = 14'h0200;
  localparam logic [13:0] MDRW  = 14'h0100;
  localparam logic [13:0] RW    = 14'h0080;
  localparam logic [13:0] M2R   = 14'h0040;
  localparam logic [13:0] ASRC  = 14'h0020;
  localparam logic [13:0] BR    = 14'h0010;
  localparam logic [13:0] PCW   = 14'h0008;
  localparam logic [13:0] PCS   = 14'h0004;
  localparam logic [13:0] HLT   = 14'h0002;
  localparam logic [13:0] ILL   = 14'h0001;

  localparam logic [31:0] I_ADDI = 32'h00A00393;
  localparam logic [31:0] I_LD   = 32'h00003383;
  localparam logic [31:0] I_BEQ  = 32'h00108463;
  localparam logic [31:0] I_SD   = 32'h0010B023;
  localparam logic [31:0] I_SLL  = 32'h002091B3;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        z;
    logic        ir;
    logic        dr;
    logic [2:0]  st;
    logic [13:0] o;
    logic [3:0]  alu;
    int unsigned ret;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  vec_t vq[$];

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [31:0] ins, input logic z,
                     input logic ir, input logic dr, input logic [2:0] st,
                     input logic [13:0] o, input logic [3:0] alu, input int unsigned ret);
    vec_t v;
    v.rst = rst; v.ins = ins; v.z = z; v.ir = ir; v.dr = dr;
    v.st = st; v.o = o; v.alu = alu; v.ret = ret;
    vq.push_back(v);
  endtask

  function automatic logic [13:0] strobes();
    return {bus.imem_req, bus.ir_write, bus.dmem_req, bus.mem_read, bus.mem_write,
            bus.mdr_write, bus.reg_write, bus.mem_to_reg, bus.alu_src, bus.branch,
            bus.pc_write, bus.pc_src, bus.halted, bus.illegal};
  endfunction

  initial begin
    logic [31:0] rins [4];
    logic [3:0]  ralu [4];
    logic        found;
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.instruction = 32'd0;
    bus.zero = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;

    // reset held, then addi with imem_ready tied high
    repeat (3) add(0, 32'd0, 0, 1, 1, 0, 14'h0, 4'h0, 0);
    add(1, I_ADDI, 0, 1, 0, 0, 14'h0, 4'h0, 0);
    add(1, I_ADDI, 0, 1, 0, 1, IMREQ | IRW, 4'h0, 0);
    add(1, I_ADDI, 0, 1, 0, 2, 14'h0, 4'h0, 0);
    add(1, I_ADDI, 0, 1, 0, 3, ASRC, 4'b0010, 0);
    add(1, I_ADDI, 0, 1, 0, 5, RW | PCW, 4'h0, 0);
    // ld: one fetch wait, stray dmem_ready outside MEMORY, 3 data wait states
    add(1, I_LD, 0, 0, 0, 1, IMREQ, 4'h0, 1);
    add(1, I_LD, 0, 1, 0, 1, IMREQ | IRW, 4'h0, 1);
    add(1, I_LD, 0, 0, 1, 2, 14'h0, 4'h0, 1);
    add(1, I_LD, 0, 0, 1, 3, ASRC, 4'b0010, 1);
    repeat (3) add(1, I_LD, 0, 0, 0, 4, DREQ | MRD, 4'h0, 1);
    add(1, I_LD, 0, 0, 1, 4, DREQ | MRD | MDRW, 4'h0, 1);
    add(1, I_LD, 0, 0, 1, 5, RW | M2R | PCW, 4'h0, 1);
    // beq taken, then not taken
    add(1, I_BEQ, 0, 1, 0, 1, IMREQ | IRW, 4'h0, 2);
    add(1, I_BEQ, 0, 1, 0, 2, 14'h0, 4'h0, 2);
    add(1, I_BEQ, 1, 1, 0, 3, BR | PCW | PCS, 4'b0110, 2);
    add(1, I_BEQ, 0, 1, 0, 1, IMREQ | IRW, 4'h0, 3);
    add(1, I_BEQ, 0, 1, 0, 2, 14'h0, 4'h0, 3);
    add(1, I_BEQ, 0, 1, 0, 3, BR | PCW, 4'b0110, 3);
    // R-type: sub, and, or, add
    rins = '{32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h002081B3};
    ralu = '{4'b0110, 4'b0000, 4'b0001, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      add(1, rins[i], 0, 1, 0, 1, IMREQ | IRW, 4'h0, 4 + i);
      add(1, rins[i], 0, 1, 0, 2, 14'h0, 4'h0, 4 + i);
      add(1, rins[i], 0, 1, 0, 3, 14'h0, ralu[i], 4 + i);
      add(1, rins[i], 0, 1, 0, 5, RW | PCW, 4'h0, 4 + i);
    end
    // sd with dmem_ready held high: consumed once in MEMORY
    add(1, I_SD, 0, 1, 1, 1, IMREQ | IRW, 4'h0, 8);
    add(1, I_SD, 0, 1, 1, 2, 14'h0, 4'h0, 8);
    add(1, I_SD, 0, 1, 1, 3, ASRC, 4'b0010, 8);
    add(1, I_SD, 0, 1, 1, 4, DREQ | MWR | PCW, 4'h0, 8);
    // all-zero instruction halts without retiring
    add(1, 32'd0, 0, 1, 1, 1, IMREQ | IRW, 4'h0, 9);
    add(1, 32'd0, 0, 1, 1, 2, 14'h0, 4'h0, 9);
    repeat (3) add(1, 32'd0, 0, 1, 1, 6, HLT, 4'h0, 9);
    // reset pulse, then unsupported R-type funct3
    add(0, I_SLL, 0, 1, 0, 0, 14'h0, 4'h0, 0);
    add(1, I_SLL, 0, 1, 0, 0, 14'h0, 4'h0, 0);
    add(1, I_SLL, 0, 1, 0, 1, IMREQ | IRW, 4'h0, 0);
    add(1, I_SLL, 0, 1, 0, 2, 14'h0, 4'h0, 0);
    add(1, I_SLL, 0, 1, 0, 3, 14'h0, 4'h0, 0);
    repeat (2) add(1, I_SLL, 0, 1, 0, 6, HLT | ILL, 4'h0, 0);
    // reset pulse, then unknown opcode 0x7F
    add(0, I_BAD, 0, 1, 0, 0, 14'h0, 4'h0, 0);
    add(1, I_BAD, 0, 1, 0, 0, 14'h0, 4'h0, 0);
    add(1, I_BAD, 0, 1, 0, 1, IMREQ | IRW, 4'h0, 0);
    add(1, I_BAD, 0, 1, 0, 2, 14'h0, 4'h0, 0);
    repeat (2) add(1, I_BAD, 0, 1, 0, 6, HLT | ILL, 4'h0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      reset           = vq[i].rst;
      bus.instruction = vq[i].ins;
      bus.zero        = vq[i].z;
      bus.imem_ready  = vq[i].ir;
      bus.dmem_ready  = vq[i].dr;
      #1;
      chk($sformatf("v%0d state", i), 64'(bus.state), 64'(vq[i].st));
      chk($sformatf("v%0d strobes", i), 64'(strobes()), 64'(vq[i].o));
      chk($sformatf("v%0d alu_ctrl", i), 64'(bus.alu_ctrl), 64'(vq[i].alu));
      chk($sformatf("v%0d instret", i), bus.instret, 64'(vq[i].ret));
    end

    // async reset while an sd waits in MEMORY, after one retired addi
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus.instruction = I_ADDI;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      #1;
      if (bus.instret == 64'd1) bus.instruction = I_SD;
      if (bus.state == 3'd4) found = 1'b1;
    end
    chk("sd reached MEMORY", 64'(found), 64'd1);
    chk("sd req before reset", 64'({bus.dmem_req, bus.mem_write}), 64'b11);
    chk("instret before reset", bus.instret, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("req drop on reset", 64'({bus.dmem_req, bus.mem_write}), 64'b00);
    chk("state on reset", 64'(bus.state), 64'd0);
    chk("instret on reset", bus.instret, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("fetch after release", 64'({bus.state, bus.imem_req}), 64'({3'd1, 1'b1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
